ula_pipe: RTL

- Parametrised, pipelined successor to the combinational Mic-1 ULA.
- Implements the Mic-1 ALU function set: F0/F1/ENA/ENB/INVA/INC, the SLL8/SRA1 shifter, and N/Z flags, at generic WIDTH.
- Two registered stages with valid/ready handshakes at input and output, so the datapath can run at higher clock rates and tolerate a stalling consumer (MBR/register-file write-back).

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_shifter.sv | 25 ++
 rtl/ula_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared constants for the pipelined Mic-1 ULA: select bit positions,
// ALU function codes and frequently used select words.
package ula_pkg;

  localparam int SEL_SLL8 = 7;
  localparam int SEL_SRA1 = 6;
  localparam int SEL_F0   = 5;
  localparam int SEL_F1   = 4;
  localparam int SEL_ENA  = 3;
  localparam int SEL_ENB  = 2;
  localparam int SEL_INVA = 1;
  localparam int SEL_INC  = 0;

  localparam logic [1:0] FN_AND  = 2'b00;
  localparam logic [1:0] FN_OR   = 2'b01;
  localparam logic [1:0] FN_NOTB = 2'b10;
  localparam logic [1:0] FN_ADD  = 2'b11;

  localparam logic [7:0] SEL_PASS_A = 8'b00011000;
  localparam logic [7:0] SEL_PASS_B = 8'b00010100;

endpackage

// File: rtl/ula_shifter.sv
// Mic-1 output shifter: SLL by SHIFT_BYTE or arithmetic SRA by 1.
// Both requests at once pass the data through and flag illegal.
module ula_shifter #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_BYTE = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic             sll8,
  input  logic             sra1,
  output logic [WIDTH-1:0] dout,
  output logic             illegal
);

  always_comb begin
    dout    = din;
    illegal = 1'b0;
    case ({sll8, sra1})
      2'b10:   dout = din << SHIFT_BYTE;
      2'b01:   dout = {din[WIDTH-1], din[WIDTH-1:1]};
      2'b11:   illegal = 1'b1;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/ula_pipe.sv
// Two-stage pipelined Mic-1 ULA with valid/ready at both ends.
// Define ULA_PIPE_CARRY_EN to add the registered adder carry-out port CO.
module ula_pipe
  import ula_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_BYTE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             N,
  output logic             Z,
  output logic             illegal
`ifdef ULA_PIPE_CARRY_EN
  ,
  output logic             CO
`endif
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv;

  logic [WIDTH-1:0] opa, opb, alu_c;
  logic [WIDTH-1:0] s1_alu;
  logic             s1_n, s1_z, s1_sll8, s1_sra1;
  logic [WIDTH-1:0] sh_out;
  logic             sh_illegal;
`ifdef ULA_PIPE_CARRY_EN
  logic             co_c, s1_co;
`endif

  // A full stage may only advance once its downstream slot frees up.
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  always_comb begin
    opa   = select[SEL_ENA] ? A : '0;
    opa   = select[SEL_INVA] ? ~opa : opa;
    opb   = select[SEL_ENB] ? B : '0;
    alu_c = '0;
`ifdef ULA_PIPE_CARRY_EN
    co_c  = 1'b0;
`endif
    case ({select[SEL_F0], select[SEL_F1]})
      FN_AND:  alu_c = opa & opb;
      FN_OR:   alu_c = opa | opb;
      FN_NOTB: alu_c = ~opb;
      FN_ADD: begin
`ifdef ULA_PIPE_CARRY_EN
        {co_c, alu_c} = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, select[SEL_INC]};
`else
        alu_c = opa + opb + {{(WIDTH-1){1'b0}}, select[SEL_INC]};
`endif
      end
      default: alu_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      s1_alu      <= '0;
      s1_n        <= 1'b0;
      s1_z        <= 1'b0;
      s1_sll8     <= 1'b0;
      s1_sra1     <= 1'b0;
`ifdef ULA_PIPE_CARRY_EN
      s1_co       <= 1'b0;
`endif
    end else if (s1_adv) begin
      vld_pipe[1] <= in_valid;
      s1_alu      <= alu_c;
      s1_n        <= alu_c[WIDTH-1];
      s1_z        <= (alu_c == '0);
      s1_sll8     <= select[SEL_SLL8];
      s1_sra1     <= select[SEL_SRA1];
`ifdef ULA_PIPE_CARRY_EN
      s1_co       <= co_c;
`endif
    end
  end

  ula_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_BYTE (SHIFT_BYTE)
  ) u_shifter (
    .din     (s1_alu),
    .sll8    (s1_sll8),
    .sra1    (s1_sra1),
    .dout    (sh_out),
    .illegal (sh_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[2] <= 1'b0;
      out         <= '0;
      N           <= 1'b0;
      Z           <= 1'b0;
      illegal     <= 1'b0;
`ifdef ULA_PIPE_CARRY_EN
      CO          <= 1'b0;
`endif
    end else if (s2_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      out         <= sh_out;
      N           <= s1_n;
      Z           <= s1_z;
      illegal     <= sh_illegal;
`ifdef ULA_PIPE_CARRY_EN
      CO          <= s1_co;
`endif
    end
  end

endmodule
